// File: rtl/gpio_bank.sv
// WIDTH-pin GPIO slave on ic0: direction, atomic set/clear,
// synchronised inputs and sticky edge interrupts.
module gpio_bank #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              c_sys_rst,
    inout  wire [WIDTH-1:0]   b0_data_io,
    input  logic              ic0_c_axi_mst_wr_valid,
    input  logic [31:0]       ic0_axi_mst_wr_addr,
    input  logic [31:0]       ic0_axi_mst_wr_data,
    input  logic [3:0]        ic0_axi_mst_wr_strobe,
    input  logic              ic0_c_axi_mst_rd_valid,
    input  logic [31:0]       ic0_axi_mst_rd_addr,
    output logic              ic0_c_axi_slv_rd_ready,
    output logic [31:0]       ic0_axi_slv_rd_data,
    output logic              irq
);

    localparam int CW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] ARM = CW'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] en_q, en_d;
    logic [WIDTH-1:0] pol_q, pol_d;
    logic [WIDTH-1:0] stat_q, stat_d;
    logic [WIDTH-1:0] prev_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [CW-1:0]    arm_q;
    logic             rd_rdy_q;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             irq_q;

    logic [WIDTH-1:0] pin_in, din, edge_det, rsel;
    logic [WIDTH-1:0] wmask, wd;
    logic [31:0]      bmask;
    logic             wr_hit, rd_hit, armed;
    logic             unused_ok;

    assign pin_in = b0_data_io;
    assign din    = sync_q[SYNC_STAGES-1];
    assign armed  = (arm_q == ARM);

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign b0_data_io[i] = dir_q[i] ? dout_q[i] : 1'bz;
    end

    assign wr_hit = ic0_c_axi_mst_wr_valid &&
                    (ic0_axi_mst_wr_addr[31:5] == BASE_ADDR[31:5]);
    assign rd_hit = ic0_c_axi_mst_rd_valid &&
                    (ic0_axi_mst_rd_addr[31:5] == BASE_ADDR[31:5]);

    assign bmask = {{8{ic0_axi_mst_wr_strobe[3]}},
                    {8{ic0_axi_mst_wr_strobe[2]}},
                    {8{ic0_axi_mst_wr_strobe[1]}},
                    {8{ic0_axi_mst_wr_strobe[0]}}};
    assign wmask = bmask[WIDTH-1:0];
    assign wd    = ic0_axi_mst_wr_data[WIDTH-1:0] & wmask;

    // Static pins at reset must not look like edges while the chain fills.
    assign edge_det = armed ?
        ((din & ~prev_q & ~pol_q) | (~din & prev_q & pol_q)) : '0;

    always_comb begin
        dout_d = dout_q;
        dir_d  = dir_q;
        en_d   = en_q;
        pol_d  = pol_q;
        stat_d = stat_q;
        if (wr_hit) begin
            unique case (ic0_axi_mst_wr_addr[4:2])
                3'd0:    dout_d = (dout_q & ~wmask) | wd;
                3'd1:    dir_d  = (dir_q & ~wmask) | wd;
                3'd3:    dout_d = dout_q | wd;
                3'd4:    dout_d = dout_q & ~wd;
                3'd5:    en_d   = (en_q & ~wmask) | wd;
                3'd6:    pol_d  = (pol_q & ~wmask) | wd;
                3'd7:    stat_d = stat_q & ~wd;
                default: ;
            endcase
        end
        stat_d = stat_d | edge_det;
    end

    always_comb begin
        rsel = '0;
        unique case (ic0_axi_mst_rd_addr[4:2])
            3'd0:    rsel = dout_q;
            3'd1:    rsel = dir_q;
            3'd2:    rsel = din;
            3'd5:    rsel = en_q;
            3'd6:    rsel = pol_q;
            3'd7:    rsel = stat_q;
            default: rsel = '0;
        endcase
        rd_data_d = '0;
        rd_data_d[WIDTH-1:0] = rd_hit ? rsel : '0;
    end

    always_ff @(posedge clk or negedge c_sys_rst) begin
        if (!c_sys_rst) begin
            dout_q    <= '0;
            dir_q     <= '0;
            en_q      <= '0;
            pol_q     <= '0;
            stat_q    <= '0;
            prev_q    <= '0;
            sync_q    <= '0;
            arm_q     <= '0;
            rd_rdy_q  <= 1'b0;
            rd_data_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            dir_q     <= dir_d;
            en_q      <= en_d;
            pol_q     <= pol_d;
            stat_q    <= stat_d;
            prev_q    <= din;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pin_in};
            if (!armed) arm_q <= arm_q + 1'b1;
            rd_rdy_q  <= rd_hit;
            rd_data_q <= rd_data_d;
            irq_q     <= |(stat_q & en_q);
        end
    end

    assign ic0_c_axi_slv_rd_ready = rd_rdy_q;
    assign ic0_axi_slv_rd_data    = rd_data_q;
    assign irq                    = irq_q;

    assign unused_ok = ^{bmask, ic0_axi_mst_wr_data,
                         ic0_axi_mst_wr_addr[1:0],
                         ic0_axi_mst_rd_addr[1:0]};

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: vector table, directed
// interrupt/reset sequences and a randomised run against a model.
module tb_gpio_bank;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic        rd_valid = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        irq;
    wire  [7:0]  pins;
    logic [7:0]  tbval = '0;
    logic [7:0]  tb_oe = '0;
    logic        mon_on = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_dout = '0, m_dir = '0, m_en = '0;
    logic [7:0]  m_pol = '0, m_stat = '0;
    logic        m_rdy = 1'b0, m_irq = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [7:0]  hist[$];

    for (genvar i = 0; i < 8; i++) begin : g_drv
        assign pins[i] = tb_oe[i] ? tbval[i] : 1'bz;
    end

    gpio_bank #(.WIDTH(8), .BASE_ADDR(32'h2000), .SYNC_STAGES(S)) dut (
        .clk(clk),
        .c_sys_rst(rst_n),
        .b0_data_io(pins),
        .ic0_c_axi_mst_wr_valid(wr_valid),
        .ic0_axi_mst_wr_addr(wr_addr),
        .ic0_axi_mst_wr_data(wr_data),
        .ic0_axi_mst_wr_strobe(wr_strb),
        .ic0_c_axi_mst_rd_valid(rd_valid),
        .ic0_axi_mst_rd_addr(rd_addr),
        .ic0_c_axi_slv_rd_ready(rd_ready),
        .ic0_axi_slv_rd_data(rd_data),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] samp(input int j);
        if (j < 1 || j > hist.size()) return 8'h0;
        return hist[j-1];
    endfunction

    function automatic logic is_hit(input logic [31:0] a);
        return (a >> 5) == (32'h2000 >> 5);
    endfunction

    // Pin value sampled at edge j is hist[j-1]; DATA_IN lags S edges.
    task automatic model_step();
        logic [7:0] pv, cur, prv, ev, m, wd;
        int j;
        pv = (m_dir & m_dout) | (~m_dir & tbval);
        hist.push_back(pv);
        j = hist.size();
        cur = samp(j - S);
        prv = samp(j - S - 1);
        ev = (j >= S + 2) ?
             ((~m_pol & cur & ~prv) | (m_pol & ~cur & prv)) : 8'h0;
        m_irq = |(m_stat & m_en);
        m_rdy = rd_valid && is_hit(rd_addr);
        m_rdata = '0;
        if (m_rdy) begin
            case (rd_addr[4:2])
                3'd0: m_rdata = {24'h0, m_dout};
                3'd1: m_rdata = {24'h0, m_dir};
                3'd2: m_rdata = {24'h0, cur};
                3'd5: m_rdata = {24'h0, m_en};
                3'd6: m_rdata = {24'h0, m_pol};
                3'd7: m_rdata = {24'h0, m_stat};
                default: m_rdata = '0;
            endcase
        end
        m = {8{wr_strb[0]}};
        wd = wr_data[7:0] & m;
        if (wr_valid && is_hit(wr_addr)) begin
            case (wr_addr[4:2])
                3'd0: m_dout = (m_dout & ~m) | wd;
                3'd1: m_dir  = (m_dir & ~m) | wd;
                3'd3: m_dout = m_dout | wd;
                3'd4: m_dout = m_dout & ~wd;
                3'd5: m_en   = (m_en & ~m) | wd;
                3'd6: m_pol  = (m_pol & ~m) | wd;
                3'd7: m_stat = m_stat & ~wd;
                default: ;
            endcase
        end
        m_stat = m_stat | ev;
    endtask

    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_dout = '0; m_dir = '0; m_en = '0;
                m_pol = '0; m_stat = '0;
                m_rdy = 1'b0; m_rdata = '0; m_irq = 1'b0;
                hist.delete();
            end else begin
                model_step();
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            tb_oe = ~m_dir;
            if (mon_on) begin
                chk("mon_rdy", 32'(rd_ready), 32'(m_rdy));
                chk("mon_data", rd_data, m_rdata);
                chk("mon_irq", 32'(irq), 32'(m_irq));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic bus(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp, input string nm);
        logic h;
        wr_valid = w; wr_addr = a; wr_data = d; wr_strb = s;
        rd_valid = r; rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        h = is_hit(a);
        if (r) begin
            chk({nm, "_rdy"}, 32'(rd_ready), 32'(h));
            chk({nm, "_data"}, rd_data, h ? exp : 32'h0);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b1, 1'b0, a, d, 4'hF, 32'h0, "wr");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e,
                      input string nm);
        bus(1'b0, 1'b1, a, 32'h0, 4'h0, e, nm);
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        logic [31:0] b;
        r = int'($urandom_range(0, 15));
        b = (r == 0) ? 32'h3000 : ((r == 1) ? 32'h2020 : 32'h2000);
        return b | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
    endfunction

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] e;
    } vec_t;

    vec_t tbl[$];

    initial begin : stim
        tbl.push_back('{1, 0, 32'h2004, 32'hFF, 4'hF, 32'h0});
        tbl.push_back('{1, 0, 32'h2000, 32'hA5, 4'hF, 32'h0});
        tbl.push_back('{1, 0, 32'h200C, 32'h0A, 4'hF, 32'h0});
        tbl.push_back('{0, 1, 32'h2000, 32'h0, 4'h0, 32'hAF});
        tbl.push_back('{1, 0, 32'h2010, 32'h81, 4'hF, 32'h0});
        tbl.push_back('{0, 1, 32'h2000, 32'h0, 4'h0, 32'h2E});
        tbl.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{0, 1, 32'h2008, 32'h0, 4'h0, 32'h2E});
        tbl.push_back('{0, 1, 32'h200C, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{0, 1, 32'h2010, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{1, 0, 32'h2000, 32'hFF, 4'h0, 32'h0});
        tbl.push_back('{0, 1, 32'h2000, 32'h0, 4'h0, 32'h2E});
        tbl.push_back('{1, 0, 32'h2000, 32'hFF, 4'h2, 32'h0});
        tbl.push_back('{0, 1, 32'h2000, 32'h0, 4'h0, 32'h2E});
        tbl.push_back('{1, 0, 32'h2000, 32'hFF, 4'h1, 32'h0});
        tbl.push_back('{0, 1, 32'h2000, 32'h0, 4'h0, 32'hFF});
        tbl.push_back('{1, 1, 32'h3000, 32'h12, 4'hF, 32'h0});
        tbl.push_back('{0, 1, 32'h2000, 32'h0, 4'h0, 32'hFF});
        tbl.push_back('{1, 1, 32'h2000, 32'h55, 4'hF, 32'hFF});
        tbl.push_back('{0, 1, 32'h2000, 32'h0, 4'h0, 32'h55});
        tbl.push_back('{1, 0, 32'h2004, 32'hFFFF_FFFF, 4'hF, 32'h0});
        tbl.push_back('{0, 1, 32'h2007, 32'h0, 4'h0, 32'hFF});

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd(32'h2004, 32'h0, "rst_dir");

        foreach (tbl[i])
            bus(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].s,
                tbl[i].e, $sformatf("vec%0d", i));

        wr(32'h2004, 32'h00);
        idle(4);
        wr(32'h2018, 32'h00);
        wr(32'h201C, 32'hFF);
        wr(32'h2014, 32'h01);
        idle(2);
        chk("irq_idle", 32'(irq), 32'h0);

        tbval[0] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rise_irq_k%0d", c), 32'(irq), 32'(c == 4));
        end
        rd(32'h201C, 32'h01, "rise_stat");
        wr(32'h201C, 32'h01);
        chk("w1c_irq_hold", 32'(irq), 32'h1);
        idle(1);
        chk("w1c_irq_fall", 32'(irq), 32'h0);

        tbval[1] = 1'b1;
        idle(4);
        wr(32'h2018, 32'h02);
        wr(32'h201C, 32'hFF);
        tbval[1] = 1'b0;
        idle(4);
        rd(32'h201C, 32'h02, "fall_stat");
        tbval[1] = 1'b1;
        idle(4);
        tbval[1] = 1'b0;
        idle(2);
        wr(32'h201C, 32'h02);
        rd(32'h201C, 32'h02, "race_stat");
        wr(32'h201C, 32'h02);
        rd(32'h201C, 32'h00, "w1c_stat");

        tbval[0] = 1'b0;
        idle(4);
        tbval[0] = 1'b1;
        idle(5);
        chk("pre_rst_irq", 32'(irq), 32'h1);
        rd_valid = 1'b1;
        rd_addr = 32'h2004;
        @(posedge clk);
        #3;
        chk("pre_rst_rdy", 32'(rd_ready), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_rdy", 32'(rd_ready), 32'h0);
        chk("rst_data", rd_data, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rd_valid = 1'b0;
        idle(2);
        rst_n = 1'b1;
        rd(32'h2004, 32'h0, "rst2_dir");
        idle(6);
        rd(32'h201C, 32'h0, "arm_stat");

        for (int n = 0; n < 1500; n++) begin
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_addr = pick_addr();
            wr_data = $urandom;
            wr_strb = 4'($urandom);
            rd_valid = 1'($urandom);
            rd_addr = pick_addr();
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) tbval[b] = ~tbval[b];
            @(posedge clk);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
